// File: rtl/fifo_ctrl_ext_status_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the FIFO pointer/status controller and the
// FIFO top that pairs it with the dual-port register file.
//   DEFAULT_ADDR_WIDTH          : default address width (depth = 2**width)
//   DEFAULT_ALMOST_FULL_THRESH  : default almost-full level for that width
//   DEFAULT_ALMOST_EMPTY_THRESH : default almost-empty level
//   fifo_status_t               : bundled status flags for the FIFO top
// ----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH          = 4;
  localparam int DEFAULT_ALMOST_FULL_THRESH  = (2 ** DEFAULT_ADDR_WIDTH) - 2;
  localparam int DEFAULT_ALMOST_EMPTY_THRESH = 2;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage : fifo_pkg

// File: rtl/fifo_ctrl_ext_status.sv
// ----------------------------------------------------------------------------
// fifo_ctrl_ext_status
// Pointer and occupancy controller for a FIFO built on a dual-port register
// file (asynchronous read, synchronous write). Turns push/pop requests into
// the register file write enable and addresses, and reports status flags
// decoded from the registered occupancy count.
//
// Ports:
//   clk_i           : clock, rising edge
//   rst_ni          : asynchronous active-low reset
//   wr_i            : push request
//   rd_i            : pop request
//   err_clr_i       : clears sticky error flags (FIFO_ERR_FLAGS_EN only)
//   write_en_o      : register file write enable (combinational)
//   write_address_o : register file write address (write pointer)
//   read_address_o  : register file read address (read pointer, head word)
//   full_o          : occupancy equals depth
//   empty_o         : occupancy is zero
//   almost_full_o   : occupancy >= ALMOST_FULL_THRESH
//   almost_empty_o  : occupancy <= ALMOST_EMPTY_THRESH
//   word_count_o    : occupancy, 0..2**ADDR_WIDTH
//   overflow_o      : sticky push-while-full flag (FIFO_ERR_FLAGS_EN only)
//   underflow_o     : sticky pop-while-empty flag (FIFO_ERR_FLAGS_EN only)
//
// Build option: define FIFO_ERR_FLAGS_EN to add the sticky error flags.
// ----------------------------------------------------------------------------
module fifo_ctrl_ext_status
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH          = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_THRESH = DEFAULT_ALMOST_EMPTY_THRESH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_i,
  input  logic                  rd_i,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic                  err_clr_i,
  output logic                  overflow_o,
  output logic                  underflow_o,
`endif
  output logic                  write_en_o,
  output logic [ADDR_WIDTH-1:0] write_address_o,
  output logic [ADDR_WIDTH-1:0] read_address_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] AE_CNT    = CW'(ALMOST_EMPTY_THRESH);

  // Reject threshold settings that would make the almost flags meaningless.
  if (!((ALMOST_EMPTY_THRESH >= 0) &&
        (ALMOST_EMPTY_THRESH < ALMOST_FULL_THRESH) &&
        (ALMOST_FULL_THRESH <= (2 ** ADDR_WIDTH)))) begin : g_bad_thresh
    $error("fifo_ctrl_ext_status: need 0 <= ALMOST_EMPTY_THRESH < ALMOST_FULL_THRESH <= depth");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_wr, do_rd;
  fifo_status_t          status;

  // Flags decode only the registered count, so they never glitch with inputs.
  always_comb begin
    status.full         = (count_q == DEPTH_CNT);
    status.empty        = (count_q == '0);
    status.almost_full  = (count_q >= AF_CNT);
    status.almost_empty = (count_q <= AE_CNT);
  end

  // A push into a full FIFO is only legal when a pop frees the head slot at
  // the same edge; a pop from an empty FIFO is never legal, so there is no
  // same-cycle fall-through of a word being written.
  always_comb begin
    do_wr = wr_i & (~status.full | rd_i);
    do_rd = rd_i & ~status.empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky flags; a new error in the clearing cycle wins over the clear.
  always_comb begin
    overflow_d  = (overflow_q  & ~err_clr_i) | (wr_i & status.full & ~rd_i);
    underflow_d = (underflow_q & ~err_clr_i) | (rd_i & status.empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

  assign write_en_o      = do_wr;
  assign write_address_o = wr_ptr_q;
  assign read_address_o  = rd_ptr_q;
  assign full_o          = status.full;
  assign empty_o         = status.empty;
  assign almost_full_o   = status.almost_full;
  assign almost_empty_o  = status.almost_empty;
  assign word_count_o    = count_q;

endmodule : fifo_ctrl_ext_status
